// File: rtl/nand_pkg.sv
// Shared types for the NAND-derived vector logic unit.
// Holds the op-code enum and its width.
package nand_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NAND  = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_PASS  = 3'd7
  } op_e;

endpackage

// File: rtl/nand_logic_core.sv
// Combinational bitwise op unit built only from 2-input NANDs.
// Ports: a, b (WIDTH) operands; op select; y (WIDTH) result.
module nand_logic_core
  import nand_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  function automatic logic [WIDTH-1:0] nd(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    return ~(x & z);
  endfunction

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] na;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] t_and;
  logic [WIDTH-1:0] t_or;
  logic [WIDTH-1:0] t_nor;
  logic [WIDTH-1:0] ta;
  logic [WIDTH-1:0] tb;
  logic [WIDTH-1:0] t_xor;
  logic [WIDTH-1:0] t_xnor;
  logic [WIDTH-1:0] t_pass;

  assign n      = nd(a, b);
  assign na     = nd(a, a);
  assign nb     = nd(b, b);
  assign t_and  = nd(n, n);
  assign t_or   = nd(na, nb);
  assign t_nor  = nd(t_or, t_or);
  assign ta     = nd(a, n);
  assign tb     = nd(b, n);
  assign t_xor  = nd(ta, tb);
  assign t_xnor = nd(t_xor, t_xor);
  assign t_pass = nd(na, na);

  always_comb begin
    y = '0;
    unique case (op)
      OP_NAND:  y = n;
      OP_AND:   y = t_and;
      OP_OR:    y = t_or;
      OP_NOR:   y = t_nor;
      OP_XOR:   y = t_xor;
      OP_XNOR:  y = t_xnor;
      OP_NOT_A: y = na;
      OP_PASS:  y = t_pass;
    endcase
  end

endmodule

// File: rtl/nand_vec_unit.sv
// Two-stage elastic pipeline around nand_logic_core with result
// flags and a wrapping delivered-result counter.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with
// in_a, in_b, in_op; out_valid/out_ready with out_y, out_zero,
// out_ones; result_cnt counts output handshakes.
module nand_vec_unit
  import nand_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] result_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
  logic             s2_ones;

  logic [WIDTH-1:0] core_y;
  logic             s1_load;
  logic             s2_load;
  logic             out_fire;

  // A stage loads when empty or when its beat leaves this cycle.
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign out_fire = s2_valid & out_ready;

  nand_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a (s1_a),
    .b (s1_b),
    .op(s1_op),
    .y (core_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_a  <= in_a;
      s1_b  <= in_b;
      s1_op <= op_e'(in_op);
    end
  end

  // Output data is reset so an idle unit shows y=0 with zero set.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_zero  <= 1'b1;
      s2_ones  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_y     <= core_y;
      s2_zero  <= (core_y == '0);
      s2_ones  <= &core_y;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_cnt <= '0;
    end else if (out_fire) begin
      result_cnt <= result_cnt + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_zero  = s2_zero;
  assign out_ones  = s2_ones;

endmodule

// File: tb/tb_nand_vec_unit.sv
// Scoreboard bench for nand_vec_unit (WIDTH=8), with a second
// instance at CNT_W=3 sharing the stimulus to observe counter wrap.
module tb_nand_vec_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;

  logic         in_ready, out_valid, out_zero, out_ones;
  logic [W-1:0] out_y;
  logic [15:0]  result_cnt;

  logic         in_ready2, out_valid2, out_zero2, out_ones2;
  logic [W-1:0] out_y2;
  logic [2:0]   cnt2;

  always #5 clk = ~clk;

  nand_vec_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones),
    .result_cnt(result_cnt)
  );

  nand_vec_unit #(.WIDTH(W), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_y(out_y2), .out_zero(out_zero2), .out_ones(out_ones2),
    .result_cnt(cnt2)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp;
  } beat_t;

  typedef struct {
    logic [W-1:0] exp;
    int           cyc;
  } sb_t;

  beat_t tx_q[$];
  sb_t   sb_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_cnt = 0;
  int acc_total = 0;
  bit acc_flag = 0;
  bit rst_flag = 0;
  bit lat_chk = 0;
  bit stall_prev = 0;
  logic [W-1:0] y_prev = '0;

  function automatic logic [W-1:0] ref_y(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b
  );
    case (op)
      3'd0: return ~(a & b);
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // Monitor: samples handshakes on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (reset) begin
      sb_q.delete();
      model_cnt = 0;
      acc_flag = 0;
      rst_flag = 1;
      stall_prev = 0;
    end else begin
      rst_flag = 0;
      chk("cnt", {16'd0, result_cnt}, model_cnt % 65536);
      chk("cnt3", {29'd0, cnt2}, model_cnt % 8);
      if (stall_prev && out_valid) chk("hold", {24'd0, out_y}, {24'd0, y_prev});
      stall_prev = out_valid && !out_ready;
      y_prev = out_y;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got y=%0h expected none", out_y);
        end else begin
          e = sb_q.pop_front();
          chk("y", {24'd0, out_y}, {24'd0, e.exp});
          chk("y_w3", {24'd0, out_y2}, {24'd0, e.exp});
          chk("zero", {31'd0, out_zero}, {31'd0, (e.exp == '0)});
          chk("ones", {31'd0, out_ones}, {31'd0, (&e.exp)});
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
        model_cnt++;
      end
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
        acc_total++;
        sb_q.push_back('{tx_q[0].exp, cyc});
      end
    end
  end

  // Driver: presents the head of tx_q, advancing on acceptance.
  always @(posedge clk) begin
    #1;
    if (rst_flag) tx_q.delete();
    else if (acc_flag) void'(tx_q.pop_front());
    if (tx_q.size() > 0) begin
      in_valid = 1'b1;
      in_a = tx_q[0].a;
      in_b = tx_q[0].b;
      in_op = tx_q[0].op;
    end else begin
      in_valid = 1'b0;
    end
  end

  task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic [W-1:0] exp);
    beat_t bt;
    bt.a = a;
    bt.b = b;
    bt.op = op;
    bt.exp = exp;
    tx_q.push_back(bt);
  endtask

  task automatic push_rand();
    logic [W-1:0] a, b;
    logic [2:0] op;
    a = W'($urandom);
    b = W'($urandom);
    op = 3'($urandom_range(0, 7));
    push_beat(a, b, op, ref_y(op, a, b));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_q.size() == 0 && sb_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
      step(1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name,
               sb_q.size() + tx_q.size());
    end
  endtask

  logic [W-1:0] tt [8];
  int base;

  initial begin
    tt = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    step(2);
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_y", {24'd0, out_y}, 0);
    chk("rst_zero", {31'd0, out_zero}, 1);
    chk("rst_ones", {31'd0, out_ones}, 0);
    chk("rst_cnt", {16'd0, result_cnt}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);

    lat_chk = 1;
    for (int op = 0; op < 8; op++)
      push_beat(8'hF0, 8'hCC, 3'(op), tt[op]);
    wait_idle("truth");
    lat_chk = 0;
    chk("tt_cnt", {16'd0, result_cnt}, 8);

    push_beat(8'h0F, 8'hF0, 3'd1, 8'h00);
    push_beat(8'h00, 8'h00, 3'd0, 8'hFF);
    wait_idle("flags");

    out_ready = 1'b0;
    base = acc_total;
    for (int i = 0; i < 5; i++) push_rand();
    step(6);
    chk("bp_accepts", acc_total - base, 2);
    chk("bp_ready", {31'd0, in_ready}, 0);
    chk("bp_valid", {31'd0, out_valid}, 1);
    base = model_cnt;
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_delivered", model_cnt - base, 5);

    lat_chk = 1;
    base = model_cnt;
    for (int i = 0; i < 100; i++) push_rand();
    wait_idle("thru");
    lat_chk = 0;
    chk("thru_delivered", model_cnt - base, 100);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_rand();
    step(4);
    chk("mid_full", {31'd0, in_ready}, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_valid", {31'd0, out_valid}, 0);
    chk("mid_cnt", {16'd0, result_cnt}, 0);
    chk("mid_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b1;
    push_rand();
    wait_idle("post_rst");
    for (int i = 0; i < 8; i++) push_rand();
    wait_idle("wrap");
    chk("wrap_cnt3", {29'd0, cnt2}, 1);
    chk("cnt9", {16'd0, result_cnt}, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
